// File: rtl/gmii_rx_frame_checker.sv
// GMII receive-side frame checker: strips preamble/SFD, checks FCS, length and IFG,
// and forwards the payload (FCS removed) as a valid-only AXI-stream.
module gmii_rx_frame_checker #(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518,
    parameter int MIN_IFG          = 12,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_enable,
    input  logic [7:0]           gmii_d,
    input  logic                 gmii_en,
    input  logic                 gmii_er,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 frame_good,
    output logic                 frame_bad_fcs,
    output logic                 frame_bad_len,
    output logic                 frame_err,
    output logic                 preamble_err,
    output logic                 ifg_violation,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_count
);

    localparam int LEN_W = $clog2(MAX_FRAME_LENGTH + 2);
    localparam int IFG_W = $clog2(MIN_IFG + 1);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_FRAME_LENGTH);
    localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_FRAME_LENGTH);
    localparam logic [LEN_W-1:0] LEN_FULL    = LEN_W'(5);
    localparam logic [IFG_W-1:0] IFG_MIN     = IFG_W'(MIN_IFG);
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t               state_q, state_d;
    logic [39:0]          shift_q, shift_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [31:0]          crc_q, crc_d;
    logic                 er_seen_q, er_seen_d;
    logic                 en_prev_q, en_prev_d;
    logic [IFG_W-1:0]     ifg_cnt_q, ifg_cnt_d;
    logic                 have_prev_q, have_prev_d;
    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 tuser_q, tuser_d;
    logic                 good_q, good_d;
    logic                 bad_fcs_q, bad_fcs_d;
    logic                 bad_len_q, bad_len_d;
    logic                 err_q, err_d;
    logic                 pre_q, pre_d;
    logic                 ifg_q, ifg_d;
    logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
    logic                 good_inc, bad_inc;
    logic                 fcs_bad, len_bad, frame_is_bad;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        len_d        = len_q;
        crc_d        = crc_q;
        er_seen_d    = er_seen_q;
        en_prev_d    = gmii_en;
        ifg_cnt_d    = ifg_cnt_q;
        have_prev_d  = have_prev_q;
        tdata_d      = tdata_q;
        tvalid_d     = 1'b0;
        tlast_d      = 1'b0;
        tuser_d      = 1'b0;
        good_d       = 1'b0;
        bad_fcs_d    = 1'b0;
        bad_len_d    = 1'b0;
        err_d        = 1'b0;
        pre_d        = 1'b0;
        ifg_d        = 1'b0;
        good_inc     = 1'b0;
        bad_inc      = 1'b0;
        fcs_bad      = 1'b0;
        len_bad      = 1'b0;
        frame_is_bad = 1'b0;

        // Gap is measured in enabled idle cycles and judged on the rising edge of gmii_en.
        if (gmii_en && !en_prev_q) begin
            ifg_cnt_d   = '0;
            have_prev_d = 1'b1;
            ifg_d       = have_prev_q && (ifg_cnt_q < IFG_MIN);
        end else if (!gmii_en && (ifg_cnt_q < IFG_MIN)) begin
            ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (gmii_en) begin
                    // en_prev_q is only high here right after reset, i.e. mid-frame.
                    if (en_prev_q) begin
                        state_d = DROP;
                    end else if (gmii_d == 8'h55) begin
                        state_d = PREAMBLE;
                    end else begin
                        pre_d   = 1'b1;
                        bad_inc = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_en) begin
                    pre_d   = 1'b1;
                    bad_inc = 1'b1;
                    state_d = IDLE;
                end else if (gmii_d == 8'hD5) begin
                    state_d   = DATA;
                    crc_d     = 32'hFFFFFFFF;
                    len_d     = '0;
                    er_seen_d = 1'b0;
                end else if (gmii_d != 8'h55) begin
                    pre_d   = 1'b1;
                    bad_inc = 1'b1;
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_en) begin
                    shift_d = {shift_q[31:0], gmii_d};
                    crc_d   = crc_step(crc_q, gmii_d);
                    len_d   = len_q + LEN_W'(1);
                    if (gmii_er) begin
                        er_seen_d = 1'b1;
                    end
                    if (len_q >= LEN_FULL) begin
                        tvalid_d = 1'b1;
                        tdata_d  = shift_q[39:32];
                    end
                    if (len_q == LEN_MAX) begin
                        tlast_d   = 1'b1;
                        tuser_d   = 1'b1;
                        bad_len_d = 1'b1;
                        bad_inc   = 1'b1;
                        state_d   = DROP;
                    end
                end else begin
                    // The four youngest buffered bytes are the FCS; the oldest is the last payload byte.
                    fcs_bad      = (crc_q != CRC_RESIDUE);
                    len_bad      = (len_q < LEN_MIN) || (len_q > LEN_MAX);
                    frame_is_bad = fcs_bad || len_bad || er_seen_q;
                    if (len_q >= LEN_FULL) begin
                        tvalid_d = 1'b1;
                        tdata_d  = shift_q[39:32];
                        tlast_d  = 1'b1;
                        tuser_d  = frame_is_bad;
                    end
                    bad_fcs_d = fcs_bad;
                    bad_len_d = len_bad;
                    err_d     = er_seen_q;
                    good_d    = !frame_is_bad;
                    good_inc  = !frame_is_bad;
                    bad_inc   = frame_is_bad;
                    state_d   = IDLE;
                end
            end
            DROP: begin
                if (!gmii_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        good_cnt_d = (good_inc && (good_cnt_q != '1)) ? good_cnt_q + CNT_WIDTH'(1) : good_cnt_q;
        bad_cnt_d  = (bad_inc && (bad_cnt_q != '1)) ? bad_cnt_q + CNT_WIDTH'(1) : bad_cnt_q;
    end

    // en_prev_q resets high so a frame already in flight at reset release is dropped, not parsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            len_q       <= '0;
            crc_q       <= '0;
            er_seen_q   <= 1'b0;
            en_prev_q   <= 1'b1;
            ifg_cnt_q   <= '0;
            have_prev_q <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            good_q      <= 1'b0;
            bad_fcs_q   <= 1'b0;
            bad_len_q   <= 1'b0;
            err_q       <= 1'b0;
            pre_q       <= 1'b0;
            ifg_q       <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            er_seen_q   <= er_seen_d;
            en_prev_q   <= en_prev_d;
            ifg_cnt_q   <= ifg_cnt_d;
            have_prev_q <= have_prev_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            good_q      <= good_d;
            bad_fcs_q   <= bad_fcs_d;
            bad_len_q   <= bad_len_d;
            err_q       <= err_d;
            pre_q       <= pre_d;
            ifg_q       <= ifg_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    // Registered results are held across disabled cycles and shown only in the next enabled one.
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q & clk_enable;
    assign m_axis_tlast  = tlast_q & clk_enable;
    assign m_axis_tuser  = tuser_q & clk_enable;
    assign frame_good    = good_q & clk_enable;
    assign frame_bad_fcs = bad_fcs_q & clk_enable;
    assign frame_bad_len = bad_len_q & clk_enable;
    assign frame_err     = err_q & clk_enable;
    assign preamble_err  = pre_q & clk_enable;
    assign ifg_violation = ifg_q & clk_enable;
    assign good_count    = good_cnt_q;
    assign bad_count     = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed testbench for gmii_rx_frame_checker: drives GMII frames, records the
// output stream and status pulses on the falling edge, and compares against hand-derived values.
module tb_gmii_rx_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic [7:0]  gmii_d;
    logic        gmii_en;
    logic        gmii_er;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_good;
    logic        frame_bad_fcs;
    logic        frame_bad_len;
    logic        frame_err;
    logic        preamble_err;
    logic        ifg_violation;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    always #5 clk = ~clk;

    gmii_rx_frame_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_enable   (clk_enable),
        .gmii_d       (gmii_d),
        .gmii_en      (gmii_en),
        .gmii_er      (gmii_er),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .frame_good   (frame_good),
        .frame_bad_fcs(frame_bad_fcs),
        .frame_bad_len(frame_bad_len),
        .frame_err    (frame_err),
        .preamble_err (preamble_err),
        .ifg_violation(ifg_violation),
        .good_count   (good_count),
        .bad_count    (bad_count)
    );

    logic [7:0]  payload [0:1599];
    logic [9:0]  beats [$];
    int          n_good, n_bad_fcs, n_bad_len, n_err, n_pre, n_ifg;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_good;
    logic [15:0] exp_bad;
    logic [9:0]  last_beat;

    // Beats are stored as {tuser, tlast, tdata}.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid) beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (frame_good) n_good++;
            if (frame_bad_fcs) n_bad_fcs++;
            if (frame_bad_len) n_bad_len++;
            if (frame_err) n_err++;
            if (preamble_err) n_pre++;
            if (ifg_violation) n_ifg++;
        end
    end

    task automatic drive(input logic en, input logic [7:0] d, input logic er);
        @(posedge clk);
        #1;
        gmii_en = en;
        gmii_d  = d;
        gmii_er = er;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic send_frame(input int n, input bit with_fcs, input logic [7:0] fcs_xor,
                              input int er_idx, input int gap);
        logic [31:0] crc;
        logic [7:0]  b;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, payload[i], (i == er_idx));
            crc = crc_byte(crc, payload[i]);
        end
        crc = ~crc;
        if (with_fcs) begin
            for (int k = 0; k < 4; k++) begin
                b = crc[8*k +: 8];
                if (k == 3) b = b ^ fcs_xor;
                drive(1'b1, b, 1'b0);
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_mon();
        beats.delete();
        n_good = 0; n_bad_fcs = 0; n_bad_len = 0; n_err = 0; n_pre = 0; n_ifg = 0;
    endtask

    // Counts beats whose data or tlast disagree with an n-byte payload stream.
    function automatic int beat_errors(input int n);
        int e;
        e = 0;
        for (int i = 0; i < beats.size(); i++) begin
            if (beats[i][7:0] !== payload[i] || beats[i][8] !== (i == n - 1)) e++;
        end
        return e;
    endfunction

    task automatic get_last_beat();
        last_beat = (beats.size() > 0) ? beats[beats.size() - 1] : 10'h3FF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_enable = 1'b1; gmii_en = 1'b0; gmii_d = 8'h00; gmii_er = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
            errors++; $display("[TB] FAIL reset_stream: got %h expected 0", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
        end
        checks++;
        if ({frame_good, frame_bad_fcs, frame_bad_len, frame_err, preamble_err, ifg_violation} !== 6'd0) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b expected 000000", {frame_good, frame_bad_fcs, frame_bad_len, frame_err, preamble_err, ifg_violation});
        end
        checks++;
        if (good_count !== 16'd0 || bad_count !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", good_count, bad_count);
        end
        rst_n = 1'b1;
        exp_good = 16'd0; exp_bad = 16'd0;
        for (int g = 0; g < 14; g++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(60, 1'b1, 8'h00, -1, 12);
        exp_good++;
        get_last_beat();
        checks++;
        if (beats.size() !== 60) begin errors++; $display("[TB] FAIL good_beats: got %0d expected 60", beats.size()); end
        checks++;
        if (beat_errors(60) !== 0) begin errors++; $display("[TB] FAIL good_data: got %0d bad beats expected 0", beat_errors(60)); end
        checks++;
        if (last_beat[9] !== 1'b0) begin errors++; $display("[TB] FAIL good_tuser: got %b expected 0", last_beat[9]); end
        checks++;
        if (n_good !== 1) begin errors++; $display("[TB] FAIL good_pulse: got %0d expected 1", n_good); end
        checks++;
        if (n_bad_fcs + n_bad_len + n_err + n_pre + n_ifg !== 0) begin
            errors++; $display("[TB] FAIL good_no_err: got %0d error pulses expected 0", n_bad_fcs + n_bad_len + n_err + n_pre + n_ifg);
        end
        checks++;
        if (good_count !== exp_good || bad_count !== exp_bad) begin
            errors++; $display("[TB] FAIL good_counts: got %0d/%0d expected %0d/%0d", good_count, bad_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_bad_fcs();
        clear_mon();
        send_frame(60, 1'b1, 8'h01, -1, 12);
        exp_bad++;
        get_last_beat();
        checks++;
        if (beats.size() !== 60 || beat_errors(60) !== 0) begin
            errors++; $display("[TB] FAIL fcs_beats: got %0d beats (%0d bad) expected 60 (0 bad)", beats.size(), beat_errors(60));
        end
        checks++;
        if (last_beat[9] !== 1'b1) begin errors++; $display("[TB] FAIL fcs_tuser: got %b expected 1", last_beat[9]); end
        checks++;
        if (n_bad_fcs !== 1 || n_good !== 0) begin
            errors++; $display("[TB] FAIL fcs_pulses: got fcs=%0d good=%0d expected fcs=1 good=0", n_bad_fcs, n_good);
        end
        checks++;
        if (good_count !== exp_good || bad_count !== exp_bad) begin
            errors++; $display("[TB] FAIL fcs_counts: got %0d/%0d expected %0d/%0d", good_count, bad_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_length_limits();
        clear_mon();
        send_frame(20, 1'b1, 8'h00, -1, 12);
        exp_bad++;
        get_last_beat();
        checks++;
        if (beats.size() !== 20 || beat_errors(20) !== 0) begin
            errors++; $display("[TB] FAIL short_beats: got %0d beats (%0d bad) expected 20 (0 bad)", beats.size(), beat_errors(20));
        end
        checks++;
        if (last_beat[9] !== 1'b1 || n_bad_len !== 1 || n_bad_fcs !== 0) begin
            errors++; $display("[TB] FAIL short_status: got tuser=%b len=%0d fcs=%0d expected 1/1/0", last_beat[9], n_bad_len, n_bad_fcs);
        end

        clear_mon();
        send_frame(3, 1'b0, 8'h00, -1, 12);
        exp_bad++;
        checks++;
        if (beats.size() !== 0 || n_bad_len !== 1) begin
            errors++; $display("[TB] FAIL tiny_frame: got beats=%0d len=%0d expected 0/1", beats.size(), n_bad_len);
        end

        clear_mon();
        send_frame(59, 1'b1, 8'h00, -1, 12);
        exp_bad++;
        checks++;
        if (beats.size() !== 59 || n_bad_len !== 1 || n_good !== 0) begin
            errors++; $display("[TB] FAIL len63: got beats=%0d len=%0d good=%0d expected 59/1/0", beats.size(), n_bad_len, n_good);
        end

        clear_mon();
        send_frame(1514, 1'b1, 8'h00, -1, 12);
        exp_good++;
        checks++;
        if (beats.size() !== 1514 || beat_errors(1514) !== 0 || n_good !== 1) begin
            errors++; $display("[TB] FAIL len1518: got beats=%0d bad=%0d good=%0d expected 1514/0/1", beats.size(), beat_errors(1514), n_good);
        end

        clear_mon();
        send_frame(1515, 1'b1, 8'h00, -1, 12);
        exp_bad++;
        get_last_beat();
        checks++;
        if (beats.size() !== 1514 || beat_errors(1514) !== 0) begin
            errors++; $display("[TB] FAIL long_beats: got %0d beats (%0d bad) expected 1514 (0 bad)", beats.size(), beat_errors(1514));
        end
        checks++;
        if (last_beat[9] !== 1'b1 || n_bad_len !== 1 || n_good !== 0 || n_bad_fcs !== 0) begin
            errors++; $display("[TB] FAIL long_status: got tuser=%b len=%0d good=%0d fcs=%0d expected 1/1/0/0", last_beat[9], n_bad_len, n_good, n_bad_fcs);
        end
        checks++;
        if (good_count !== exp_good || bad_count !== exp_bad) begin
            errors++; $display("[TB] FAIL len_counts: got %0d/%0d expected %0d/%0d", good_count, bad_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_preamble_err();
        clear_mon();
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAB, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h11, 1'b0);
        for (int g = 0; g < 12; g++) drive(1'b0, 8'h00, 1'b0);
        exp_bad++;
        checks++;
        if (n_pre !== 1 || beats.size() !== 0) begin
            errors++; $display("[TB] FAIL preamble: got pre=%0d beats=%0d expected 1/0", n_pre, beats.size());
        end
        checks++;
        if (bad_count !== exp_bad) begin errors++; $display("[TB] FAIL preamble_count: got %0d expected %0d", bad_count, exp_bad); end
        clear_mon();
        send_frame(60, 1'b1, 8'h00, -1, 12);
        exp_good++;
        checks++;
        if (n_good !== 1 || beats.size() !== 60 || good_count !== exp_good) begin
            errors++; $display("[TB] FAIL after_preamble: got good=%0d beats=%0d cnt=%0d expected 1/60/%0d", n_good, beats.size(), good_count, exp_good);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(60, 1'b1, 8'h00, -1, 8);
        send_frame(60, 1'b1, 8'h00, -1, 12);
        exp_good = exp_good + 16'd2;
        checks++;
        if (n_ifg !== 1) begin errors++; $display("[TB] FAIL ifg_pulse: got %0d expected 1", n_ifg); end
        checks++;
        if (n_good !== 2 || beats.size() !== 120 || good_count !== exp_good) begin
            errors++; $display("[TB] FAIL ifg_frames: got good=%0d beats=%0d cnt=%0d expected 2/120/%0d", n_good, beats.size(), good_count, exp_good);
        end
    endtask

    task automatic test_gmii_err();
        clear_mon();
        send_frame(60, 1'b1, 8'h00, 10, 12);
        exp_bad++;
        get_last_beat();
        checks++;
        if (n_err !== 1 || n_good !== 0 || n_bad_fcs !== 0) begin
            errors++; $display("[TB] FAIL gmii_err: got err=%0d good=%0d fcs=%0d expected 1/0/0", n_err, n_good, n_bad_fcs);
        end
        checks++;
        if (beats.size() !== 60 || last_beat[9] !== 1'b1 || bad_count !== exp_bad) begin
            errors++; $display("[TB] FAIL gmii_err_out: got beats=%0d tuser=%b bad=%0d expected 60/1/%0d", beats.size(), last_beat[9], bad_count, exp_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, payload[i], 1'b0);
        drive(1'b1, payload[30], 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || good_count !== 16'd0 || bad_count !== 16'd0) begin
            errors++; $display("[TB] FAIL mid_reset_clear: got tvalid=%b cnt=%0d/%0d expected 0/0/0", m_axis_tvalid, good_count, bad_count);
        end
        drive(1'b1, payload[31], 1'b0);
        drive(1'b1, payload[32], 1'b0);
        rst_n = 1'b1;
        clear_mon();
        exp_good = 16'd0; exp_bad = 16'd0;
        for (int i = 33; i < 64; i++) drive(1'b1, payload[i], 1'b0);
        for (int g = 0; g < 12; g++) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (beats.size() !== 0 || n_good + n_bad_fcs + n_bad_len + n_err + n_pre + n_ifg !== 0) begin
            errors++; $display("[TB] FAIL mid_reset_quiet: got beats=%0d pulses=%0d expected 0/0", beats.size(), n_good + n_bad_fcs + n_bad_len + n_err + n_pre + n_ifg);
        end
        clear_mon();
        send_frame(60, 1'b1, 8'h00, -1, 12);
        exp_good++;
        checks++;
        if (good_count !== exp_good || bad_count !== exp_bad || beats.size() !== 60 || n_ifg !== 0) begin
            errors++; $display("[TB] FAIL mid_reset_next: got cnt=%0d/%0d beats=%0d ifg=%0d expected 1/0/60/0", good_count, bad_count, beats.size(), n_ifg);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1600; i++) payload[i] = i[7:0];
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_length_limits();
        test_preamble_err();
        test_back_to_back();
        test_gmii_err();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
